// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipeline: framebuffer address issue, latency-matched
// colour/sync/blank outputs and frame-boundary test patterns.
module vga_pixel_pipe #(
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int SCALE_SHIFT = 1,
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 17,
  parameter int CNT_W       = 10
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [CNT_W-1:0]  H_COUNT,
  input  logic [CNT_W-1:0]  V_COUNT,
  input  logic              H_SYNC_IN,
  input  logic              V_SYNC_IN,
  input  logic [1:0]        PATTERN_SEL,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_EN,
  input  logic [7:0]        RD_DATA,
  output logic [7:0]        RED,
  output logic [7:0]        GREEN,
  output logic [7:0]        BLUE,
  output logic              BLANK_N,
  output logic              H_SYNC,
  output logic              V_SYNC,
  output logic              FRAME_START,
  output logic [15:0]       FRAME_COUNT
);

  // Stage 1 plus MEM_LATENCY stages; the output register adds the last one.
  localparam int D = MEM_LATENCY + 1;

  typedef struct packed {
    logic             vis;
    logic             hs;
    logic             vs;
    logic             sof;
    logic [1:0]       mode;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
  } pix_t;

  localparam pix_t PIX_RST = '{
    vis: 1'b0, hs: 1'b1, vs: 1'b1, sof: 1'b0,
    mode: 2'd0, h: '0, v: '0
  };

  pix_t dl_q [D];
  pix_t dl_d [D];

  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic [7:0]        red_q, red_d;
  logic [7:0]        grn_q, grn_d;
  logic [7:0]        blu_q, blu_d;
  logic              blank_q, blank_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              fs_q, fs_d;
  logic [15:0]       fc_q, fc_d;

  logic       vis0;
  logic       sof0;
  logic [1:0] mode_eff;
  logic [2:0] bar;

  // A pattern request seen together with sof applies to that same pixel.
  always_comb begin
    vis0 = (H_COUNT < CNT_W'(H_VISIBLE))
        && (V_COUNT < CNT_W'(V_VISIBLE));
    sof0 = (H_COUNT == '0) && (V_COUNT == '0);
    mode_eff = sof0 ? PATTERN_SEL : mode_q;
    mode_d = mode_eff;
    rd_en_d = vis0 && (mode_eff == 2'd0);
    rd_addr_d = rd_addr_q;
    if (rd_en_d) begin
      rd_addr_d =
        ADDR_W'(V_COUNT >> SCALE_SHIFT)
        * ADDR_W'(H_VISIBLE >> SCALE_SHIFT)
        + ADDR_W'(H_COUNT >> SCALE_SHIFT);
    end
    dl_d[0] = '{
      vis: vis0, hs: H_SYNC_IN, vs: V_SYNC_IN,
      sof: sof0, mode: mode_eff,
      h: H_COUNT, v: V_COUNT
    };
    for (int i = 1; i < D; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (dl_q[D-1].h >= CNT_W'(i * (H_VISIBLE / 8))) begin
        bar = 3'(i);
      end
    end
    red_d = 8'h00;
    grn_d = 8'h00;
    blu_d = 8'h00;
    if (dl_q[D-1].vis) begin
      unique case (dl_q[D-1].mode)
        2'd0: begin
          red_d = {RD_DATA[7:5], RD_DATA[7:5], RD_DATA[7:6]};
          grn_d = {RD_DATA[4:2], RD_DATA[4:2], RD_DATA[4:3]};
          blu_d = {4{RD_DATA[1:0]}};
        end
        2'd1: begin
          red_d = {8{~bar[1]}};
          grn_d = {8{~bar[2]}};
          blu_d = {8{~bar[0]}};
        end
        2'd2: begin
          red_d = {8{~(dl_q[D-1].h[5] ^ dl_q[D-1].v[5])}};
          grn_d = red_d;
          blu_d = red_d;
        end
        default: begin
          red_d = 8'h00;
        end
      endcase
    end
    blank_d = dl_q[D-1].vis;
    hs_d = dl_q[D-1].hs;
    vs_d = dl_q[D-1].vs;
    fs_d = dl_q[D-1].sof;
    fc_d = fc_q + {15'd0, dl_q[D-1].sof};
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      mode_q <= 2'd0;
      rd_addr_q <= '0;
      rd_en_q <= 1'b0;
      for (int i = 0; i < D; i++) begin
        dl_q[i] <= PIX_RST;
      end
      red_q <= 8'h00;
      grn_q <= 8'h00;
      blu_q <= 8'h00;
      blank_q <= 1'b0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      fs_q <= 1'b0;
      fc_q <= 16'd0;
    end else begin
      mode_q <= mode_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q <= rd_en_d;
      for (int i = 0; i < D; i++) begin
        dl_q[i] <= dl_d[i];
      end
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
      blank_q <= blank_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fs_q <= fs_d;
      fc_q <= fc_d;
    end
  end

  assign RD_ADDR = rd_addr_q;
  assign RD_EN = rd_en_q;
  assign RED = red_q;
  assign GREEN = grn_q;
  assign BLUE = blu_q;
  assign BLANK_N = blank_q;
  assign H_SYNC = hs_q;
  assign V_SYNC = vs_q;
  assign FRAME_START = fs_q;
  assign FRAME_COUNT = fc_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: vector table and multi-cycle sequences
// checked through a latency-L expected-output queue.
module tb_vga_pixel_pipe;

  localparam int L = 4;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [9:0]  H_COUNT = '0;
  logic [9:0]  V_COUNT = '0;
  logic        H_SYNC_IN = 1'b1;
  logic        V_SYNC_IN = 1'b1;
  logic [1:0]  PATTERN_SEL = 2'd0;
  logic [16:0] RD_ADDR;
  logic        RD_EN;
  logic [7:0]  RD_DATA;
  logic [7:0]  RED, GREEN, BLUE;
  logic        BLANK_N, H_SYNC, V_SYNC, FRAME_START;
  logic [15:0] FRAME_COUNT;

  vga_pixel_pipe dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .H_COUNT(H_COUNT), .V_COUNT(V_COUNT),
    .H_SYNC_IN(H_SYNC_IN), .V_SYNC_IN(V_SYNC_IN),
    .PATTERN_SEL(PATTERN_SEL),
    .RD_ADDR(RD_ADDR), .RD_EN(RD_EN), .RD_DATA(RD_DATA),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .BLANK_N(BLANK_N), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC),
    .FRAME_START(FRAME_START), .FRAME_COUNT(FRAME_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  // Memory returning addr[7:0], valid two cycles after the RD_EN cycle.
  logic [7:0] m1 = 8'h00;
  logic [7:0] m2 = 8'h00;
  always @(posedge CLOCK) begin
    m1 <= RD_ADDR[7:0];
    m2 <= m1;
  end
  assign RD_DATA = m2;

  typedef struct {
    logic [23:0] rgb;
    logic        bl, hs, vs, fs;
    logic [15:0] fc;
  } exp_t;

  typedef struct {
    int          h, v;
    logic        hs, vs;
    logic [1:0]  ps;
    logic [23:0] rgb;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[18];
  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;
  int fs_seen = 0;
  logic [1:0] mode_m = 2'd0;
  logic [15:0] fc_m = 16'd0;

  logic [23:0] bars [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [23:0] model(int h, int v, logic [1:0] m);
    int a, r3, g3, b2;
    if (!(h < 640 && v < 480)) return 24'h0;
    case (m)
      2'd0: begin
        a = (v / 2) * 320 + (h / 2);
        a = a % 256;
        r3 = a / 32;
        g3 = (a / 4) % 8;
        b2 = a % 4;
        return {8'(r3 * 36 + r3 / 2), 8'(g3 * 36 + g3 / 2),
                8'(b2 * 85)};
      end
      2'd1: return bars[h / 80];
      2'd2: return (((h / 32) + (v / 32)) % 2 == 0) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  task automatic check(string nm, logic ok, logic [63:0] got,
                       logic [63:0] want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic drive(int h, int v, logic hs, logic vs,
                       logic [1:0] ps, logic use_tbl, logic [23:0] trgb);
    exp_t e, g;
    logic sof;
    H_COUNT = 10'(h);
    V_COUNT = 10'(v);
    H_SYNC_IN = hs;
    V_SYNC_IN = vs;
    PATTERN_SEL = ps;
    sof = (h == 0 && v == 0);
    if (sof) begin
      mode_m = ps;
      fc_m = fc_m + 16'd1;
    end
    e.rgb = use_tbl ? trgb : model(h, v, mode_m);
    e.bl = (h < 640 && v < 480);
    e.hs = hs;
    e.vs = vs;
    e.fs = sof;
    e.fc = fc_m;
    sbq.push_back(e);
    @(posedge CLOCK);
    #1;
    if (FRAME_START) fs_seen++;
    g.rgb = {RED, GREEN, BLUE};
    g.bl = BLANK_N;
    g.hs = H_SYNC;
    g.vs = V_SYNC;
    g.fs = FRAME_START;
    g.fc = FRAME_COUNT;
    if (sbq.size() == L) begin
      e = sbq.pop_front();
      n_cmp++;
      if (g != e) begin
        n_bad++;
        $display("FAIL pix%0d got rgb=%h bl=%b hs=%b vs=%b fs=%b fc=%0d want rgb=%h bl=%b hs=%b vs=%b fs=%b fc=%0d",
                 n_pop, g.rgb, g.bl, g.hs, g.vs, g.fs, g.fc,
                 e.rgb, e.bl, e.hs, e.vs, e.fs, e.fc);
      end
      n_pop++;
    end else begin
      check("post_reset_hold",
            g.rgb == 0 && !g.bl && g.hs && g.vs && !g.fs && g.fc == 0,
            64'({g.rgb, g.bl, g.hs, g.vs, g.fs, g.fc}),
            64'({24'h0, 4'b0110, 16'h0}));
    end
  endtask

  task automatic do_reset(int n, int h, int v, logic [1:0] ps);
    RESET_N = 1'b0;
    H_COUNT = 10'(h);
    V_COUNT = 10'(v);
    H_SYNC_IN = 1'b0;
    V_SYNC_IN = 1'b0;
    PATTERN_SEL = ps;
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      #1;
      check("reset_vals",
            RD_ADDR == 0 && !RD_EN && {RED, GREEN, BLUE} == 0
            && !BLANK_N && H_SYNC && V_SYNC && !FRAME_START
            && FRAME_COUNT == 0,
            64'({RD_ADDR, RD_EN, RED, GREEN, BLUE, BLANK_N, H_SYNC,
                 V_SYNC, FRAME_START, FRAME_COUNT}),
            64'({17'h0, 1'b0, 24'h0, 4'b0110, 16'h0}));
    end
    sbq.delete();
    mode_m = 2'd0;
    fc_m = 16'd0;
    RESET_N = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{0,   0,   1'b1, 1'b1, 2'd0, 24'h000000};
    tbl[1]  = '{3,   3,   1'b0, 1'b1, 2'd0, 24'h490055};
    tbl[2]  = '{639, 0,   1'b1, 1'b0, 2'd0, 24'h24FFFF};
    tbl[3]  = '{640, 0,   1'b0, 1'b0, 2'd0, 24'h000000};
    tbl[4]  = '{5,   525, 1'b1, 1'b0, 2'd0, 24'h000000};
    tbl[5]  = '{100, 10,  1'b1, 1'b1, 2'd1, 24'h6D92AA};
    tbl[6]  = '{0,   0,   1'b0, 1'b1, 2'd1, 24'hFFFFFF};
    tbl[7]  = '{80,  0,   1'b1, 1'b1, 2'd1, 24'hFFFF00};
    tbl[8]  = '{159, 1,   1'b1, 1'b0, 2'd1, 24'hFFFF00};
    tbl[9]  = '{560, 2,   1'b0, 1'b1, 2'd1, 24'h000000};
    tbl[10] = '{639, 3,   1'b1, 1'b1, 2'd1, 24'h000000};
    tbl[11] = '{240, 4,   1'b1, 1'b1, 2'd2, 24'h00FF00};
    tbl[12] = '{0,   0,   1'b1, 1'b1, 2'd2, 24'hFFFFFF};
    tbl[13] = '{32,  0,   1'b0, 1'b0, 2'd2, 24'h000000};
    tbl[14] = '{32,  32,  1'b1, 1'b1, 2'd2, 24'hFFFFFF};
    tbl[15] = '{0,   0,   1'b1, 1'b1, 2'd3, 24'h000000};
    tbl[16] = '{300, 200, 1'b0, 1'b1, 2'd0, 24'h000000};
    tbl[17] = '{0,   0,   1'b1, 1'b1, 2'd0, 24'h000000};

    do_reset(3, 100, 100, 2'd1);

    foreach (tbl[i]) begin
      drive(tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].ps,
            1'b1, tbl[i].rgb);
    end

    drive(3, 3, 1'b1, 1'b1, 2'd0, 1'b0, 24'h0);
    check("rd_addr_3_3", RD_ADDR == 17'd321 && RD_EN,
          64'({RD_EN, RD_ADDR}), 64'({1'b1, 17'd321}));
    drive(639, 0, 1'b1, 1'b1, 2'd0, 1'b0, 24'h0);
    check("rd_addr_639", RD_ADDR == 17'd319 && RD_EN,
          64'({RD_EN, RD_ADDR}), 64'({1'b1, 17'd319}));
    drive(640, 0, 1'b1, 1'b1, 2'd0, 1'b0, 24'h0);
    check("rd_en_640_hold", RD_ADDR == 17'd319 && !RD_EN,
          64'({RD_EN, RD_ADDR}), 64'({1'b0, 17'd319}));
    drive(5, 525, 1'b1, 1'b1, 2'd0, 1'b0, 24'h0);
    check("rd_en_v525", !RD_EN, 64'(RD_EN), 64'(0));
    for (int i = 0; i < L; i++) begin
      drive(700, 500, 1'b1, 1'b1, 2'd0, 1'b0, 24'h0);
    end

    drive(0, 0, 1'b1, 1'b1, 2'd2, 1'b0, 24'h0);
    drive(40, 8, 1'b1, 1'b1, 2'd2, 1'b0, 24'h0);
    drive(10, 10, 1'b0, 1'b1, 2'd2, 1'b0, 24'h0);
    do_reset(3, 10, 10, 2'd2);
    drive(2, 2, 1'b0, 1'b0, 2'd2, 1'b0, 24'h0);
    drive(3, 2, 1'b0, 1'b1, 2'd2, 1'b0, 24'h0);
    drive(64, 40, 1'b1, 1'b0, 2'd2, 1'b0, 24'h0);
    for (int i = 0; i < L; i++) begin
      drive(20 + i, 6, 1'b1, 1'b1, 2'd2, 1'b0, 24'h0);
    end

    fs_seen = 0;
    for (int f = 0; f < 3; f++) begin
      for (int v = 0; v < 4; v++) begin
        for (int h = 0; h < 12; h++) begin
          drive(h, v, !(h >= 8 && h < 10), v != 3, 2'd0, 1'b0, 24'h0);
        end
      end
    end
    for (int i = 0; i < L; i++) begin
      drive(700, 500, 1'b1, 1'b1, 2'd0, 1'b0, 24'h0);
    end
    check("frame_pulses", fs_seen == 3, 64'(fs_seen), 64'(3));
    check("frame_count", FRAME_COUNT == 16'd3,
          64'(FRAME_COUNT), 64'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
